// File: rtl/addr8s_sched.sv
// Two-requester scheduler for one shared external 8-bit signed adder.
// Define ADDR8S_SCHED_REDUNDANT_EN for swapped-operand re-execution and compare.
module addr8s_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [8:0]       rsp0_sum,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [8:0]       rsp1_sum,
  output logic             rsp1_err,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [8:0]       add_sum,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE, EXEC1, EXEC2, RESP
  } state_t;

  state_t     state;
  logic [7:0] a_q, b_q;
  logic       gid, last;
  logic       gnt_v, gnt_id, accept, rsp_hs;

  // Ties go to the requester not granted last; last resets to 1.
  assign gnt_v  = req0_valid | req1_valid;
  assign gnt_id = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign accept = (state == IDLE) & ~rst & gnt_v;

  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;
  assign rsp0_valid = (state == RESP) & ~gid;
  assign rsp1_valid = (state == RESP) & gid;
  assign rsp_hs     = gid ? rsp1_ready : rsp0_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    add_a = 8'h00;
    add_b = 8'h00;
    unique case (state)
      EXEC1: begin
        add_a = a_q;
        add_b = b_q;
      end
      EXEC2: begin
        add_a = b_q;
        add_b = a_q;
      end
      default: ;
    endcase
  end

`ifdef ADDR8S_SCHED_REDUNDANT_EN
  logic [8:0] res;
  logic       mis;

  assign mis = (add_sum != res);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      gid      <= 1'b0;
      last     <= 1'b1;
      rsp0_sum <= 9'h000;
      rsp1_sum <= 9'h000;
`ifdef ADDR8S_SCHED_REDUNDANT_EN
      res      <= 9'h000;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_v) begin
            a_q   <= gnt_id ? req1_a : req0_a;
            b_q   <= gnt_id ? req1_b : req0_b;
            gid   <= gnt_id;
            last  <= gnt_id;
            state <= EXEC1;
          end
        end
        EXEC1: begin
`ifdef ADDR8S_SCHED_REDUNDANT_EN
          res   <= add_sum;
          state <= EXEC2;
`else
          if (gid) rsp1_sum <= add_sum;
          else     rsp0_sum <= add_sum;
          state <= RESP;
`endif
        end
        EXEC2: begin
`ifdef ADDR8S_SCHED_REDUNDANT_EN
          if (gid) rsp1_sum <= res;
          else     rsp0_sum <= res;
`endif
          state <= RESP;
        end
        RESP: begin
          if (rsp_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDR8S_SCHED_REDUNDANT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
      err_cnt  <= '0;
    end else if (state == EXEC2) begin
      if (gid) rsp1_err <= mis;
      else     rsp0_err <= mis;
      if (mis && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_addr8s_sched.sv
// Directed bench for addr8s_sched with a behavioural adder model.
// Fault injection flips bit0 on the swapped phase of 03+10.
module tb_addr8s_sched;

`ifdef ADDR8S_SCHED_REDUNDANT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready;
  logic [8:0] rsp0_sum;
  logic       rsp0_err;
  logic       rsp1_valid, rsp1_ready;
  logic [8:0] rsp1_sum;
  logic       rsp1_err;
  logic [7:0] add_a, add_b;
  logic [8:0] add_sum;
  logic       busy;
  logic [7:0] err_cnt;
  logic       fault_en;
  logic       flip;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign flip    = fault_en && add_a == 8'h10 && add_b == 8'h03;
  assign add_sum = ({add_a[7], add_a} + {add_b[7], add_b}) ^ {8'h00, flip};

  addr8s_sched #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_sum   (rsp0_sum),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_sum   (rsp1_sum),
    .rsp1_err   (rsp1_err),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // One full transaction on requester id; returns response and latency.
  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input bit full, output logic [8:0] sum,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("accept_timeout", n, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    if (full) begin
      chk("exec1_add_a", add_a, a);
      chk("exec1_add_b", add_b, b);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(id ? rsp1_valid : rsp0_valid) && lat < 20);
    if (full) chk("other_valid", id ? rsp0_valid : rsp1_valid, 0);
    sum = id ? rsp1_sum : rsp0_sum;
    err = id ? rsp1_err : rsp0_err;
    @(posedge clk); #1;
  endtask

  logic [8:0] s;
  logic       e;
  int         lat, seq, n, ops0, ops1, both, cyc;
  bit         ok, seen;

  initial begin
    rst = 1; fault_en = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    req0_valid = 1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_sums", {rsp0_sum, rsp1_sum}, 0);
    chk("rst_errs", {rsp0_err, rsp1_err}, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_add", {add_a, add_b}, 0);
    req0_valid = 0;
    @(negedge clk);
    rst = 0;

    run_op(0, 8'h7F, 8'h7F, 1, s, e, lat);
    chk("op_7f7f_sum", s, 9'h0FE);
    chk("op_7f7f_err", e, 0);
    chk("op_7f7f_lat", lat, LAT);
    run_op(1, 8'h80, 8'h80, 1, s, e, lat);
    chk("op_8080_sum", s, 9'h100);
    chk("op_8080_lat", lat, LAT);
    run_op(1, 8'h05, 8'hFB, 1, s, e, lat);
    chk("op_05fb_sum", s, 9'h000);
    run_op(0, 8'h81, 8'hFF, 1, s, e, lat);
    chk("op_81ff_sum", s, 9'h180);
    chk("idle_busy", busy, 0);

    // Response backpressure while requester 1 waits.
    @(negedge clk);
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20;
    #1;
    chk("stall_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp0_valid && n < 20);
    chk("stall_rsp_seen", rsp0_valid, 1);
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      ok &= rsp0_valid && rsp0_sum == 9'h030 && busy && !req1_ready;
    end
    chk("stall_hold", ok, 1);
    rsp0_ready = 1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!req1_ready && n < 20);
    chk("stall_next_accept", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp1_valid && n < 20);
    chk("stall_next_sum", rsp1_sum, 9'h003);
    @(posedge clk); #1;

    // Round-robin from reset with both requesters contending.
    pulse_rst();
    seq = 0; n = 0; ops0 = 0; ops1 = 0; both = 0; cyc = 0;
    req0_a = 8'h01; req0_b = 8'h01;
    req1_a = 8'h02; req1_b = 8'h02;
    while (n < 6 && cyc < 100) begin
      req0_valid = ops0 < 3;
      req1_valid = ops1 < 3;
      #1;
      if (req0_ready && req1_ready) both++;
      if (req0_ready) begin seq = seq * 2; n++; ops0++; end
      else if (req1_ready) begin seq = seq * 2 + 1; n++; ops1++; end
      @(negedge clk);
      cyc++;
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("rr_order", seq, 21);
    chk("rr_count", n, 6);
    chk("rr_both", both, 0);
    repeat (6) @(negedge clk);

    // Reset while the operation sits in EXEC1.
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h06;
    @(posedge clk); #1;
    req0_valid = 0;
    chk("mid_busy_pre", busy, 1);
    rst = 1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_add", {add_a, add_b}, 0);
    chk("mid_sums", {rsp0_sum, rsp1_sum}, 0);
    chk("mid_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); seen |= rsp0_valid | rsp1_valid; end
    chk("mid_no_rsp", seen, 0);
    run_op(0, 8'h05, 8'h06, 1, s, e, lat);
    chk("mid_after_sum", s, 9'h00B);

    // Fault injection on the swapped phase.
    fault_en = 1;
    run_op(0, 8'h03, 8'h10, 1, s, e, lat);
    chk("flt_sum", s, 9'h013);
`ifdef ADDR8S_SCHED_REDUNDANT_EN
    chk("flt_err", e, 1);
    chk("flt_cnt1", err_cnt, 8'h01);
    for (int i = 0; i < 255; i++) run_op(i[0], 8'h03, 8'h10, 0, s, e, lat);
    chk("flt_cnt_sat", err_cnt, 8'hFF);
    run_op(1, 8'h03, 8'h10, 0, s, e, lat);
    chk("flt_err1", e, 1);
    chk("flt_cnt_hold", err_cnt, 8'hFF);
    run_op(0, 8'h04, 8'h10, 0, s, e, lat);
    chk("flt_clean_err", e, 0);
    chk("flt_clean_sum", s, 9'h014);
`else
    chk("flt_err_off", e, 0);
    chk("flt_cnt_off", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
